// File: rtl/apb_regfile_slave_if.sv
// rtl/apb_regfile_slave_if.sv - APB3 bus bundle for apb_regfile_slave
// PSTRB (APB4) is present only when APB_REGFILE_PSTRB_EN is defined.
interface apb_regfile_slave_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic                    PSEL;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [ADDR_WIDTH-1:0]   PADDR;
  logic [DATA_WIDTH-1:0]   PWDATA;
`ifdef APB_REGFILE_PSTRB_EN
  logic [DATA_WIDTH/8-1:0] PSTRB;
`endif
  logic [DATA_WIDTH-1:0]   PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;

  modport master (
`ifdef APB_REGFILE_PSTRB_EN
    output PSTRB,
`endif
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
`ifdef APB_REGFILE_PSTRB_EN
    input  PSTRB,
`endif
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_regfile_slave.sv
// rtl/apb_regfile_slave.sv - APB3 register-file slave with wait states, decode errors and read-only ID slot
// Optional byte strobes (APB4 PSTRB) enabled by defining APB_REGFILE_PSTRB_EN.
module apb_regfile_slave #(
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    NUM_REGS    = 8,
  parameter int                    WAIT_STATES = 0,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE    = 32'hA9B0_0001,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                           PCLK,
  input  logic                           PRESET,
  apb_regfile_slave_if.slave             bus,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam int NB    = DATA_WIDTH / 8;

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic [DATA_WIDTH-1:0] slots [1:NUM_REGS-1];
  logic [IDX_W-1:0]      idx;
  logic                  err;
  logic                  load;
  logic                  wr_en;
  logic [NB-1:0]         wr_be;
  logic [DATA_WIDTH-1:0] rd_word;

  assign idx = bus.PADDR[ADDR_WIDTH-1:2];

  always_comb begin
    err = (bus.PADDR[1:0] != 2'b00)
       || ({1'b0, idx} >= (IDX_W+1)'(NUM_REGS))
       || (bus.PWRITE && (idx == '0));
`ifdef APB_REGFILE_PSTRB_EN
    err   = err || (!bus.PWRITE && (bus.PSTRB != '0));
    wr_be = bus.PSTRB;
`else
    wr_be = '1;
`endif
  end

  always_comb begin
    rd_word = ID_VALUE;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (idx == IDX_W'(i)) rd_word = slots[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    prdata_d  = prdata_q;
    load      = 1'b0;
    wr_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.PSEL && !bus.PENABLE) begin
          state_d  = ACCESS;
          cnt_d    = 4'(WAIT_STATES);
          pready_d = (WAIT_STATES == 0);
          load     = (WAIT_STATES == 0);
        end
      end
      ACCESS: begin
        if (!bus.PSEL) begin
          // Master abandoned the transfer: drop it without side effects.
          state_d   = IDLE;
          cnt_d     = '0;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
        end else if (pready_q && bus.PENABLE) begin
          wr_en     = bus.PWRITE && !err;
          state_d   = IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            pready_d = 1'b1;
            load     = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      pslverr_d = err;
      if (!bus.PWRITE) prdata_d = err ? '0 : rd_word;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int i = 1; i < NUM_REGS; i++) slots[i] <= RESET_VALUE;
    end else if (wr_en) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (idx == IDX_W'(i)) begin
          for (int b = 0; b < NB; b++) begin
            if (wr_be[b]) slots[i][b*8 +: 8] <= bus.PWDATA[b*8 +: 8];
          end
        end
      end
    end
  end

  assign bus.PRDATA  = prdata_q;
  assign bus.PREADY  = pready_q;
  assign bus.PSLVERR = pslverr_q;

  assign reg_out[DATA_WIDTH-1:0] = ID_VALUE;
  for (genvar g = 1; g < NUM_REGS; g++) begin : g_out
    assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = slots[g];
  end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// tb/tb_apb_regfile_slave.sv - randomized self-checking bench for apb_regfile_slave
// Two instances: index 0 with no wait states, index 1 with three.
module tb_apb_regfile_slave;
  localparam logic [31:0] ID = 32'hA9B0_0001;

  logic PCLK = 1'b0;
  logic PRESET;
  always #5 PCLK = ~PCLK;

  logic        psel[2], penable[2], pwrite[2];
  logic [15:0] paddr[2];
  logic [31:0] pwdata[2];
  logic [3:0]  pstrb[2];
  logic [31:0] prdata_o[2];
  logic        pready_o[2], pslverr_o[2];
  logic [255:0] rout0, rout3;

  apb_regfile_slave_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus0 ();
  apb_regfile_slave_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus3 ();

  assign bus0.PSEL = psel[0];  assign bus0.PENABLE = penable[0];  assign bus0.PWRITE = pwrite[0];
  assign bus0.PADDR = paddr[0]; assign bus0.PWDATA = pwdata[0];
  assign bus3.PSEL = psel[1];  assign bus3.PENABLE = penable[1];  assign bus3.PWRITE = pwrite[1];
  assign bus3.PADDR = paddr[1]; assign bus3.PWDATA = pwdata[1];
`ifdef APB_REGFILE_PSTRB_EN
  assign bus0.PSTRB = pstrb[0];
  assign bus3.PSTRB = pstrb[1];
`endif
  assign prdata_o[0] = bus0.PRDATA; assign pready_o[0] = bus0.PREADY; assign pslverr_o[0] = bus0.PSLVERR;
  assign prdata_o[1] = bus3.PRDATA; assign pready_o[1] = bus3.PREADY; assign pslverr_o[1] = bus3.PSLVERR;

  apb_regfile_slave #(.WAIT_STATES(0)) dut0 (.PCLK(PCLK), .PRESET(PRESET), .bus(bus0), .reg_out(rout0));
  apb_regfile_slave #(.WAIT_STATES(3)) dut3 (.PCLK(PCLK), .PRESET(PRESET), .bus(bus3), .reg_out(rout3));

  int tests = 0;
  int fails = 0;
  int ws[2] = '{0, 3};
  logic [31:0] model[2][8];
  logic [31:0] last_rd[2];

  function automatic logic [255:0] rout_of(input int d);
    return (d == 0) ? rout0 : rout3;
  endfunction

  function automatic logic [255:0] flat(input int d);
    logic [255:0] f;
    for (int i = 0; i < 8; i++) f[i*32 +: 32] = model[d][i];
    return f;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      model[d][0] = ID;
      for (int i = 1; i < 8; i++) model[d][i] = 32'h0;
      last_rd[d] = 32'h0;
    end
  endtask

  // Reference: decode rules with plain arithmetic, then update the word/byte image.
  task automatic model_xfer(input int d, input bit wr, input int addr, input logic [31:0] wd,
                            input logic [3:0] st, output bit e);
    int slot;
    slot = addr / 4;
    e = (addr % 4 != 0) || (slot >= 8) || (wr && slot == 0);
`ifdef APB_REGFILE_PSTRB_EN
    if (!wr && st != 0) e = 1;
`endif
    if (wr && !e) begin
`ifdef APB_REGFILE_PSTRB_EN
      for (int b = 0; b < 4; b++) if (st[b]) model[d][slot][b*8 +: 8] = wd[b*8 +: 8];
`else
      model[d][slot] = wd;
`endif
    end
    if (!wr) last_rd[d] = e ? 32'h0 : model[d][slot];
  endtask

  task automatic xfer(input int d, input bit wr, input logic [15:0] addr, input logic [31:0] wd,
                      input logic [3:0] st, output logic [31:0] rd, output logic er, output int ncyc);
    psel[d] = 1; penable[d] = 0; pwrite[d] = wr; paddr[d] = addr; pwdata[d] = wd; pstrb[d] = st;
    @(posedge PCLK); #1;
    penable[d] = 1;
    ncyc = 1;
    while (!pready_o[d] && ncyc < 40) begin
      @(posedge PCLK); #1;
      ncyc++;
    end
    rd = prdata_o[d];
    er = pslverr_o[d];
    @(posedge PCLK); #1;
    psel[d] = 0; penable[d] = 0;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      tests++; if (pready_o[d] !== 1'b0) begin fails++; $display("FAIL reset_pready d=%0d got %b want 0", d, pready_o[d]); end
      tests++; if (pslverr_o[d] !== 1'b0) begin fails++; $display("FAIL reset_pslverr d=%0d got %b want 0", d, pslverr_o[d]); end
      tests++; if (prdata_o[d] !== 32'h0) begin fails++; $display("FAIL reset_prdata d=%0d got %h want 0", d, prdata_o[d]); end
      tests++; if (rout_of(d) !== flat(d)) begin fails++; $display("FAIL reset_regout d=%0d got %h want %h", d, rout_of(d), flat(d)); end
    end
  endtask

  task automatic test_id_read();
    logic [31:0] rd; logic er; int n; bit e;
    model_xfer(0, 0, 0, 0, 0, e);
    xfer(0, 0, 16'h0000, 32'h0, 4'h0, rd, er, n);
    tests++; if (rd !== ID) begin fails++; $display("FAIL id_read got %h want %h", rd, ID); end
    tests++; if (er !== 1'b0) begin fails++; $display("FAIL id_err got %b want 0", er); end
    tests++; if (n != 1) begin fails++; $display("FAIL id_latency got %0d want 1", n); end
    tests++; if (pready_o[0] !== 1'b0) begin fails++; $display("FAIL id_pready_after got %b want 0", pready_o[0]); end
    model_xfer(0, 0, 4, 0, 0, e);
    xfer(0, 0, 16'h0004, 32'h0, 4'h0, rd, er, n);
    tests++; if (rd !== 32'h0) begin fails++; $display("FAIL slot1_read got %h want 0", rd); end
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic er; int n; bit e;
    model_xfer(0, 1, 8, 32'hDEADBEEF, 4'hF, e);
    xfer(0, 1, 16'h0008, 32'hDEADBEEF, 4'hF, rd, er, n);
    tests++; if (er !== 1'b0) begin fails++; $display("FAIL wr_err got %b want 0", er); end
    tests++; if (rout0[95:64] !== 32'hDEADBEEF) begin fails++; $display("FAIL wr_regout got %h want deadbeef", rout0[95:64]); end
    model_xfer(0, 0, 8, 0, 0, e);
    xfer(0, 0, 16'h0008, 32'h0, 4'h0, rd, er, n);
    tests++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL wr_readback got %h want deadbeef", rd); end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic er; int n; bit e;
    model_xfer(1, 0, 4, 0, 0, e);
    xfer(1, 0, 16'h0004, 32'h0, 4'h0, rd, er, n);
    tests++; if (n + 1 != 5) begin fails++; $display("FAIL ws3_length got %0d want 5", n + 1); end
    tests++; if (rd !== 32'h0 || er !== 1'b0) begin fails++; $display("FAIL ws3_read got %h/%b want 0/0", rd, er); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int n; bit e;
    int addrs[3] = '{0, 32, 6};
    bit wrs[3] = '{1, 1, 0};
    for (int k = 0; k < 3; k++) begin
      model_xfer(0, wrs[k], addrs[k], 32'h5A5A_1234, 4'hF, e);
      xfer(0, wrs[k], 16'(addrs[k]), 32'h5A5A_1234, 4'hF & {4{wrs[k]}}, rd, er, n);
      tests++; if (er !== 1'b1 || n != 1) begin fails++; $display("FAIL err_%0d got err=%b cyc=%0d want 1/1", k, er, n); end
      tests++; if (rd !== last_rd[0]) begin fails++; $display("FAIL err_rdata_%0d got %h want %h", k, rd, last_rd[0]); end
    end
    tests++; if (rout0 !== flat(0)) begin fails++; $display("FAIL err_regs got %h want %h", rout0, flat(0)); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int n; bit e;
    psel[0] = 1; penable[0] = 0; pwrite[0] = 1; paddr[0] = 16'h000C; pwdata[0] = 32'hCAFE_F00D; pstrb[0] = 4'hF;
    @(posedge PCLK); #1;
    penable[0] = 1;
    #2 PRESET = 1;
    psel[0] = 0; penable[0] = 0;
    #1;
    tests++; if (pready_o[0] !== 1'b0) begin fails++; $display("FAIL rst_mid_pready got %b want 0", pready_o[0]); end
    @(posedge PCLK); #1;
    PRESET = 0;
    model_reset();
    tests++; if (rout0[127:96] !== 32'h0) begin fails++; $display("FAIL rst_mid_slot3 got %h want 0", rout0[127:96]); end
    model_xfer(0, 0, 12, 0, 0, e);
    xfer(0, 0, 16'h000C, 32'h0, 4'h0, rd, er, n);
    tests++; if (rd !== 32'h0 || er !== 1'b0) begin fails++; $display("FAIL rst_mid_read got %h/%b want 0/0", rd, er); end
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic er; int n; bit e;
    psel[1] = 1; penable[1] = 0; pwrite[1] = 1; paddr[1] = 16'h0014; pwdata[1] = 32'h1357_9BDF; pstrb[1] = 4'hF;
    @(posedge PCLK); #1;
    penable[1] = 1;
    @(posedge PCLK); #1;
    psel[1] = 0; penable[1] = 0;
    @(posedge PCLK); #1;
    tests++; if (pready_o[1] !== 1'b0 || pslverr_o[1] !== 1'b0) begin fails++; $display("FAIL abort_flags got %b/%b want 0/0", pready_o[1], pslverr_o[1]); end
    repeat (4) @(posedge PCLK);
    #1;
    tests++; if (rout3 !== flat(1)) begin fails++; $display("FAIL abort_nowrite got %h want %h", rout3, flat(1)); end
    model_xfer(1, 0, 20, 0, 0, e);
    xfer(1, 0, 16'h0014, 32'h0, 4'h0, rd, er, n);
    tests++; if (rd !== model[1][5] || n != 4) begin fails++; $display("FAIL abort_read got %h cyc=%0d want %h cyc=4", rd, n, model[1][5]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int n; bit e;
    model_xfer(0, 1, 4, 32'h0BAD_F00D, 4'hF, e);
    xfer(0, 1, 16'h0004, 32'h0BAD_F00D, 4'hF, rd, er, n);
    model_xfer(0, 1, 28, 32'h7777_0001, 4'hF, e);
    xfer(0, 1, 16'h001C, 32'h7777_0001, 4'hF, rd, er, n);
    tests++; if (n != 1 || er !== 1'b0) begin fails++; $display("FAIL b2b_write got cyc=%0d err=%b want 1/0", n, er); end
    model_xfer(0, 0, 4, 0, 0, e);
    xfer(0, 0, 16'h0004, 32'h0, 4'h0, rd, er, n);
    tests++; if (rd !== 32'h0BAD_F00D || n != 1) begin fails++; $display("FAIL b2b_read got %h cyc=%0d want 0badf00d cyc=1", rd, n); end
    tests++; if (rout0 !== flat(0)) begin fails++; $display("FAIL b2b_regs got %h want %h", rout0, flat(0)); end
  endtask

`ifdef APB_REGFILE_PSTRB_EN
  task automatic test_pstrb();
    logic [31:0] rd; logic er; int n; bit e;
    model_xfer(0, 1, 4, 32'h1122_3344, 4'hF, e);
    xfer(0, 1, 16'h0004, 32'h1122_3344, 4'hF, rd, er, n);
    model_xfer(0, 1, 4, 32'hAABB_CCDD, 4'b0101, e);
    xfer(0, 1, 16'h0004, 32'hAABB_CCDD, 4'b0101, rd, er, n);
    model_xfer(0, 1, 4, 32'hFFFF_FFFF, 4'b0000, e);
    xfer(0, 1, 16'h0004, 32'hFFFF_FFFF, 4'b0000, rd, er, n);
    tests++; if (er !== 1'b0) begin fails++; $display("FAIL strb0_err got %b want 0", er); end
    model_xfer(0, 0, 4, 0, 0, e);
    xfer(0, 0, 16'h0004, 32'h0, 4'h0, rd, er, n);
    tests++; if (rd !== 32'h11BB_33DD) begin fails++; $display("FAIL strb_merge got %h want 11bb33dd", rd); end
    model_xfer(0, 0, 4, 0, 4'b0001, e);
    xfer(0, 0, 16'h0004, 32'h0, 4'b0001, rd, er, n);
    tests++; if (er !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL strb_read_err got %b/%h want 1/0", er, rd); end
  endtask
`endif

  task automatic test_random();
    logic [31:0] rd, wd; logic er; int n, d, addr; bit wr, e; logic [3:0] st;
    for (int k = 0; k < 80; k++) begin
      d    = $urandom_range(0, 1);
      wr   = 1'($urandom_range(0, 1));
      addr = $urandom_range(0, 39);
      wd   = $urandom;
      st   = wr ? 4'($urandom_range(0, 15)) : 4'h0;
`ifdef APB_REGFILE_PSTRB_EN
      if (!wr && $urandom_range(0, 7) == 0) st = 4'($urandom_range(1, 15));
`else
      st = 4'hF & {4{wr}};
`endif
      model_xfer(d, wr, addr, wd, st, e);
      xfer(d, wr, 16'(addr), wd, st, rd, er, n);
      tests++; if (er !== e) begin fails++; $display("FAIL rnd_err k=%0d d=%0d a=%0d got %b want %b", k, d, addr, er, e); end
      tests++; if (n != ws[d] + 1) begin fails++; $display("FAIL rnd_latency k=%0d d=%0d got %0d want %0d", k, d, n, ws[d] + 1); end
      tests++; if (rd !== last_rd[d]) begin fails++; $display("FAIL rnd_rdata k=%0d d=%0d got %h want %h", k, d, rd, last_rd[d]); end
      tests++; if (rout_of(d) !== flat(d)) begin fails++; $display("FAIL rnd_regs k=%0d d=%0d got %h want %h", k, d, rout_of(d), flat(d)); end
      repeat ($urandom_range(0, 2)) @(posedge PCLK);
      #1;
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      psel[d] = 0; penable[d] = 0; pwrite[d] = 0; paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '0;
    end
    model_reset();
    PRESET = 1;
    repeat (3) @(posedge PCLK);
    #1 PRESET = 0;
    @(posedge PCLK); #1;
    test_reset();
    test_id_read();
    test_write_read();
    test_wait_states();
    test_errors();
    test_reset_mid();
    test_abort();
    test_back_to_back();
`ifdef APB_REGFILE_PSTRB_EN
    test_pstrb();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
